multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle RV32I control unit: one FSM sequences fetch, decode, execute, memory and writeback over several clocks so one ALU and one unified memory port are shared. It adds a memory-ready handshake, optional bne/blt/bge support, an illegal-opcode pulse and a retired-instruction counter. It drives the multi-cycle datapath: PC, IR, OldPC, ALUOut and Data registers, plus the SrcA/SrcB/Result muxes.

---
 rtl/multicycle_control_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: one FSM sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port, with memory-ready stalls and a retire counter.
module multicycle_control_unit #(
  parameter bit EXT_BRANCH = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] retired_q;

  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] alu_dec;
  logic       taken;
  logic       is_cmp_branch;
  logic       retire;

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (funct7 && op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  // Without extended branches every funct3 collapses to beq.
  always_comb begin
    taken         = Zero;
    is_cmp_branch = 1'b0;
    if (EXT_BRANCH) begin
      is_cmp_branch = (funct3 == 3'b100) || (funct3 == 3'b101);
      case (funct3)
        3'b000:  taken = Zero;
        3'b001:  taken = !Zero;
        3'b100:  taken = Lt;
        3'b101:  taken = !Lt;
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BRANCH:         ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d       = FETCH;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    case (state_q)
      FETCH: begin
        result_src   = 2'b10;
        alu_src_b    = 2'b10;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
        state_d      = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default: begin
            state_d     = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = FETCH;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = MemReady ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_dec;
        state_d     = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b00;
        alu_control  = is_cmp_branch ? ALU_SLT : ALU_SUB;
        pc_write_raw = taken;
        state_d      = FETCH;
      end
      JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  // An illegal decode also returns to FETCH but deliberately does not retire.
  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                  ((state_q == MEMWRITE) && MemReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Write enables are gated by reset directly so a reset mid-access never leaks a write.
  assign PCWrite    = rst_n & pc_write_raw;
  assign MemWrite   = rst_n & mem_write_raw;
  assign IRWrite    = rst_n & ir_write_raw;
  assign RegWrite   = rst_n & reg_write_raw;
  assign Illegal    = rst_n & illegal_raw;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = alu_src_a;
  assign ALUSrcB    = alu_src_b;
  assign ALUControl = alu_control;
  assign State      = state_q;
  assign Retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit: one extended-branch 32-bit-counter instance
// and one beq-only 4-bit-counter instance share the same stimulus.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7 = 1'b0;
  logic       zero = 1'b0;
  logic       lt = 1'b0;
  logic       mem_ready = 1'b0;

  logic        a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
  logic [1:0]  a_rs, a_sa, a_sb, a_imm;
  logic [2:0]  a_alu;
  logic [3:0]  a_state;
  logic [31:0] a_ret;

  logic        b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
  logic [1:0]  b_rs, b_sa, b_sb, b_imm;
  logic [2:0]  b_alu;
  logic [3:0]  b_state;
  logic [3:0]  b_ret;

  always #5 clk = ~clk;

  multicycle_control_unit #(.EXT_BRANCH(1'b1), .CNT_W(32)) dut_ext (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(zero), .Lt(lt), .MemReady(mem_ready),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw),
    .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ImmSrc(a_imm),
    .ALUControl(a_alu), .RegWrite(a_rw), .Illegal(a_ill), .State(a_state), .Retired(a_ret)
  );

  multicycle_control_unit #(.EXT_BRANCH(1'b0), .CNT_W(4)) dut_beq (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(zero), .Lt(lt), .MemReady(mem_ready),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw), .IRWrite(b_irw),
    .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ImmSrc(b_imm),
    .ALUControl(b_alu), .RegWrite(b_rw), .Illegal(b_ill), .State(b_state), .Retired(b_ret)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, adr, mw, irw;
    logic [1:0]  rs, sa, sb, imm;
    logic [2:0]  alu;
    logic        rw, ill;
    logic [31:0] ret;
    logic        pcw0;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, l, mr;
    exp_t       x;
  } vec_t;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BR = 7'b1100011, JALOP = 7'b1101111, BAD = 7'b1111111;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   exp_ret = 0;

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                              input logic mw, input logic irw, input logic [1:0] rs,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] alu, input logic rw, input logic ill);
    exp_t r;
    r = '0;
    r.st = st; r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw;
    r.rs = rs; r.sa = sa; r.sb = sb; r.alu = alu; r.rw = rw; r.ill = ill;
    return r;
  endfunction

  function automatic exp_t s_reset();    return mk(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0); endfunction
  function automatic exp_t s_fetch(input logic mr); return mk(4'd0, mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0); endfunction
  function automatic exp_t s_decode(input logic ill); return mk(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, ill); endfunction
  function automatic exp_t s_memadr();   return mk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0); endfunction
  function automatic exp_t s_memread();  return mk(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0); endfunction
  function automatic exp_t s_memwb();    return mk(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0); endfunction
  function automatic exp_t s_memwrite(); return mk(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0); endfunction
  function automatic exp_t s_execr(input logic [2:0] alu); return mk(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0, 0); endfunction
  function automatic exp_t s_execi(input logic [2:0] alu); return mk(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0, 0); endfunction
  function automatic exp_t s_aluwb();    return mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0); endfunction
  function automatic exp_t s_branch(input logic pcw, input logic [2:0] alu); return mk(4'd9, pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0, 0); endfunction
  function automatic exp_t s_jal();      return mk(4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0); endfunction

  function automatic logic [1:0] imm_for(input logic [6:0] o);
    case (o)
      STORE:   return 2'b01;
      BR:      return 2'b10;
      JALOP:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic add_vec(input logic rst, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic l, input logic mr, input exp_t x, input logic pcw0);
    vec_t v;
    x.imm  = imm_for(o);
    x.ret  = 32'(exp_ret);
    x.pcw0 = pcw0;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.l = l; v.mr = mr; v.x = x;
    vecs.push_back(v);
  endtask

  task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                     input logic l, input logic mr, input exp_t x);
    add_vec(1'b1, o, f3, f7, z, l, mr, x, x.pcw);
  endtask

  task automatic add_rtype(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    add(RTYPE, f3, f7, 0, 0, 1, s_fetch(1));
    add(RTYPE, f3, f7, 0, 0, 1, s_decode(0));
    add(RTYPE, f3, f7, 0, 0, 1, s_execr(alu));
    add(RTYPE, f3, f7, 0, 0, 1, s_aluwb());
    exp_ret++;
  endtask

  task automatic add_itype(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    add(ITYPE, f3, f7, 0, 0, 1, s_fetch(1));
    add(ITYPE, f3, f7, 0, 0, 1, s_decode(0));
    add(ITYPE, f3, f7, 0, 0, 1, s_execi(alu));
    add(ITYPE, f3, f7, 0, 0, 1, s_aluwb());
    exp_ret++;
  endtask

  task automatic add_branch(input logic [2:0] f3, input logic z, input logic l,
                            input logic [2:0] alu, input logic tk, input logic tk_beq);
    add(BR, f3, 0, z, l, 1, s_fetch(1));
    add(BR, f3, 0, z, l, 1, s_decode(0));
    add_vec(1'b1, BR, f3, 0, z, l, 1, s_branch(tk, alu), tk_beq);
    exp_ret++;
  endtask

  task automatic checkOutput(input int idx);
    exp_t ex, act;
    if (sbq.size() == 0) begin
      n_mis++;
      $display("[TB] FAIL vec%0d scoreboard: got empty queue, required one entry", idx);
      return;
    end
    ex = sbq.pop_front();
    act = '0;
    act.st = a_state; act.pcw = a_pcw; act.adr = a_adr; act.mw = a_mw; act.irw = a_irw;
    act.rs = a_rs; act.sa = a_sa; act.sb = a_sb; act.imm = a_imm; act.alu = a_alu;
    act.rw = a_rw; act.ill = a_ill; act.ret = a_ret; act.pcw0 = b_pcw;
    n_vec++;
    if (act !== ex || b_state !== ex.st || b_ret !== ex.ret[3:0]) begin
      n_mis++;
      $display("[TB] FAIL vec%0d outputs: got %h st_b=%0d ret_b=%0d, required %h st_b=%0d ret_b=%0d",
               idx, act, b_state, b_ret, ex, ex.st, ex.ret[3:0]);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    rst_n = v.rst; op = v.op; funct3 = v.f3; funct7 = v.f7;
    zero = v.z; lt = v.l; mem_ready = v.mr;
    sbq.push_back(v.x);
    #2;
    checkOutput(idx);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], n_vec);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Main program: reset, ALU ops, stalled load/store, branches, jal, illegal opcode.
    exp_ret = 0;
    add_vec(1'b0, RTYPE, 3'b000, 0, 0, 0, 1, s_reset(), 1'b0);
    add_rtype(3'b000, 1'b0, 3'b000);
    add_rtype(3'b000, 1'b1, 3'b001);
    add(LOAD, 3'b010, 0, 0, 0, 0, s_fetch(0));
    add(LOAD, 3'b010, 0, 0, 0, 1, s_fetch(1));
    add(LOAD, 3'b010, 0, 0, 0, 0, s_decode(0));
    add(LOAD, 3'b010, 0, 0, 0, 0, s_memadr());
    add(LOAD, 3'b010, 0, 0, 0, 0, s_memread());
    add(LOAD, 3'b010, 0, 0, 0, 0, s_memread());
    add(LOAD, 3'b010, 0, 0, 0, 1, s_memread());
    add(LOAD, 3'b010, 0, 0, 0, 1, s_memwb());
    exp_ret++;
    add(STORE, 3'b010, 0, 0, 0, 1, s_fetch(1));
    add(STORE, 3'b010, 0, 0, 0, 1, s_decode(0));
    add(STORE, 3'b010, 0, 0, 0, 1, s_memadr());
    for (int i = 0; i < 3; i++) add(STORE, 3'b010, 0, 0, 0, 0, s_memwrite());
    add(STORE, 3'b010, 0, 0, 0, 1, s_memwrite());
    exp_ret++;
    add_itype(3'b000, 1'b1, 3'b000);
    add_itype(3'b100, 1'b0, 3'b100);
    add_rtype(3'b010, 1'b0, 3'b101);
    add_rtype(3'b110, 1'b0, 3'b011);
    add_rtype(3'b111, 1'b0, 3'b010);
    add_rtype(3'b001, 1'b0, 3'b000);
    add_branch(3'b000, 1, 0, 3'b001, 1, 1);
    add_branch(3'b001, 1, 0, 3'b001, 0, 1);
    add_branch(3'b100, 0, 1, 3'b101, 1, 0);
    add_branch(3'b101, 0, 1, 3'b101, 0, 0);
    add_branch(3'b101, 1, 0, 3'b101, 1, 1);
    add_branch(3'b010, 1, 0, 3'b001, 0, 1);
    add(JALOP, 3'b000, 0, 0, 0, 1, s_fetch(1));
    add(JALOP, 3'b000, 0, 0, 0, 1, s_decode(0));
    add(JALOP, 3'b000, 0, 0, 0, 1, s_jal());
    add(JALOP, 3'b000, 0, 0, 0, 1, s_aluwb());
    exp_ret++;
    add(BAD, 3'b000, 0, 0, 0, 1, s_fetch(1));
    add(BAD, 3'b000, 0, 0, 0, 1, s_decode(1));
    add_rtype(3'b000, 1'b0, 3'b000);
    run_table();

    // Asynchronous reset in the middle of a stalled store.
    add(STORE, 3'b010, 0, 0, 0, 1, s_fetch(1));
    add(STORE, 3'b010, 0, 0, 0, 1, s_decode(0));
    add(STORE, 3'b010, 0, 0, 0, 1, s_memadr());
    add(STORE, 3'b010, 0, 0, 0, 0, s_memwrite());
    exp_ret = 0;
    add_vec(1'b0, STORE, 3'b010, 0, 0, 0, 0, s_reset(), 1'b0);
    run_table();

    // Sixteen addi instructions wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) add_itype(3'b000, 1'b0, 3'b000);
    add(ITYPE, 3'b000, 0, 0, 0, 1, s_fetch(1));
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
